btn_toggle_pulse: RTL

- Converts a raw, bouncing pushbutton pad into a clean single-cycle pulse.
- Drives the t input of the toggle flip-flop stage directly downstream, so one physical press produces exactly one toggle.
- Three functions:
  - synchronises the asynchronous pad signal;
  - debounces it with a stability counter and FSM;
  - emits one pulse per confirmed press.

---
 rtl/btn_pkg.sv | 13 +
 rtl/sync_2ff.sv | 25 ++
 rtl/btn_toggle_pulse.sv | 107 ++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton debounce path.
package btn_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit synchroniser for asynchronous pad inputs.
module sync_2ff
   import btn_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_toggle_pulse.sv
// Pushbutton conditioner: synchronise, debounce, and emit one t pulse per press.
module btn_toggle_pulse
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn_raw,
   input  logic en,
   output logic t_pulse,
   output logic btn_level,
   output logic busy
);

   localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic PAD_IDLE = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic       pad_sync;
   logic       s;
   logic       cnt_last;
   btn_state_e state_q;
   logic [CNT_W-1:0] cnt_q;
   logic       fire_q;
   logic       t_pulse_q;
   logic       level_q;
   logic       busy_q;

   sync_2ff #(
      .RST_VAL (PAD_IDLE)
   ) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d_i  (btn_raw),
      .q_o  (pad_sync)
   );

   // XOR with the idle level yields an active-high "pressed" sample.
   assign s        = pad_sync ^ PAD_IDLE;
   assign cnt_last = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         fire_q    <= 1'b0;
         t_pulse_q <= 1'b0;
         level_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         level_q   <= (state_q == PRESSED) || (state_q == WAIT_RELEASE);
         busy_q    <= (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
         t_pulse_q <= fire_q;
         fire_q    <= 1'b0;
         case (state_q)
            RELEASED: begin
               if (s) begin
                  state_q <= WAIT_PRESS;
                  cnt_q   <= CNT_ONE;
               end
            end
            WAIT_PRESS: begin
               if (!s) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end else if (cnt_last) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
                  // en only matters at the accepting edge; later changes cannot fire.
                  fire_q  <= en;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!s) begin
                  state_q <= WAIT_RELEASE;
                  cnt_q   <= CNT_ONE;
               end
            end
            WAIT_RELEASE: begin
               if (s) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_last) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= RELEASED;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign t_pulse   = t_pulse_q;
   assign btn_level = level_q;
   assign busy      = busy_q;

endmodule
